// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift-register sequencer and its shift stage.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package usr_pkg;

  // Default widths: 4-bit parallel data, 2-bit mode select
  localparam int DATA_W_DEF = 4;
  localparam int SEL_W_DEF  = 2;

  // Mode encoding shared by cmd_op, sel_mux and the shift-register mux select
  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_SHR  = 2'b01,
    OP_SHL  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  // Sequencer states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Number of capture steps a command occupies: a load is always a single
  // step, otherwise a count of 0 stands for the full 8 serial bits.
  function automatic logic [3:0] steps_of(input logic [1:0] op, input logic [2:0] cnt);
    logic [3:0] n;
    if (op == OP_LOAD) begin
      n = 4'd1;
    end else if (cnt == 3'd0) begin
      n = 4'd8;
    end else begin
      n = {1'b0, cnt};
    end
    return n;
  endfunction

endpackage

// File: rtl/usr_shreg.sv
// Universal shift register stage: hold, shift right, shift left or parallel load on each enabled edge.
// Latency: q updates on the rising edge that ends an i_en cycle.
// Backpressure: none; every enabled edge is a capture.
module usr_shreg
  import usr_pkg::*;
#(
  parameter int W = DATA_W_DEF
) (
  input  logic         i_clk,
  input  logic         clr,
  input  logic         i_en,
  input  logic [1:0]   i_sel,
  input  logic [W-1:0] i_par,
  input  logic         i_sr,
  input  logic         i_sl,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Capture the selected next value on each enabled edge; clr clears the register
  always_ff @(posedge i_clk) begin
    if (clr) begin
      r_q <= '0;
    end else if (i_en) begin
      case (op_e'(i_sel))
        OP_SHR:  r_q <= {i_sr, r_q[W-1:1]};
        OP_SHL:  r_q <= {r_q[W-2:0], i_sl};
        OP_LOAD: r_q <= i_par;
        default: r_q <= r_q;
      endcase
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/usr_sequencer.sv
// Command sequencer driving a universal shift register one step per step_en pulse.
// Latency: first step outputs valid the cycle after accept; done pulses the cycle after the last step.
// Backpressure: cmd_ready is low while a command runs; cmd_valid is ignored until it returns to idle.
module usr_sequencer
  import usr_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_W_DEF,
  parameter int DATA_WIDTH1 = SEL_W_DEF
) (
  input  logic                   i_clk,
  input  logic                   clr,
  input  logic                   step_en,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [2:0]             cmd_cnt,
  input  logic [DATA_WIDTH-1:0]  cmd_data,
  input  logic [7:0]             cmd_serial,
  output logic [DATA_WIDTH1-1:0] sel_mux,
  output logic [DATA_WIDTH-1:0]  in,
  output logic                   sr,
  output logic                   sl,
  output logic                   busy,
  output logic                   done
);

  state_e                r_state;
  state_e                w_state_nxt;
  op_e                   r_op;
  logic [DATA_WIDTH-1:0] r_data;
  logic [7:0]            r_serial;
  logic [2:0]            r_idx;
  logic [3:0]            r_rem;
  logic                  r_done;

  logic                  w_accept;
  logic                  w_step;
  logic                  w_last;

  // State register; clr overrides any accept or step in the same cycle
  always_ff @(posedge i_clk) begin
    if (clr) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and all control outputs; step_en only counts while running,
  // so a step coinciding with acceptance or idle is dropped
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    cmd_ready   = 1'b0;
    busy        = 1'b0;
    sel_mux     = '0;
    sr          = 1'b0;
    sl          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        busy    = 1'b1;
        sel_mux = DATA_WIDTH1'(r_op);
        w_step  = step_en;
        w_last  = step_en && (r_rem == 4'd1);
        if (w_last) begin
          w_state_nxt = ST_IDLE;
        end
        case (r_op)
          OP_SHR:  sr = r_serial[r_idx];
          OP_SHL:  sl = r_serial[r_idx];
          default: begin
            sr = 1'b0;
            sl = 1'b0;
          end
        endcase
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Command latch, step index and remaining-step counter, one-cycle done pulse
  always_ff @(posedge i_clk) begin
    if (clr) begin
      r_op     <= OP_HOLD;
      r_data   <= '0;
      r_serial <= '0;
      r_idx    <= '0;
      r_rem    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_op     <= op_e'(cmd_op);
        r_data   <= cmd_data;
        r_serial <= cmd_serial;
        r_idx    <= '0;
        r_rem    <= steps_of(cmd_op, cmd_cnt);
      end else if (w_step) begin
        r_idx <= r_idx + 3'd1;
        r_rem <= r_rem - 4'd1;
      end
    end
  end

  // Parallel data holds the most recently latched command data
  assign in   = r_data;
  assign done = r_done;

endmodule

// File: doc/usr_sequencer.md
USR_SEQUENCER -- requirements
Module: usr_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 4, SHALL be the parallel data width driven to the shift register.
REQ-002 Parameter DATA_WIDTH1, default 2, SHALL be the mode-select width.
REQ-003 i_clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 clr  in  1  SHALL be the synchronous, active-high reset.
REQ-005 step_en  in  1  SHALL be a one-i_clk pulse marking each downstream shift-register capture edge.
REQ-006 cmd_valid  in  1  SHALL be the command-offer strobe.
REQ-007 cmd_ready  out  1  SHALL be high when a command can be accepted.
REQ-008 cmd_op  in  2  SHALL be the mode: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-009 cmd_cnt  in  3  SHALL be the step count, with 0 meaning 8.
REQ-010 cmd_data  in  DATA_WIDTH  SHALL be the load value.
REQ-011 cmd_serial  in  8  SHALL be the serial bits to shift in, consumed LSB first.
REQ-012 sel_mux  out  DATA_WIDTH1  SHALL be the mode select to the shift register, using the same encoding as cmd_op.
REQ-013 in  out  DATA_WIDTH  SHALL be the parallel load data.
REQ-014 sr  out  1  SHALL be the shift-right serial input; sl  out  1  SHALL be the shift-left serial input.
REQ-015 busy  out  1  SHALL be high while a command is executing; done  out  1  SHALL pulse for one cycle when a command completes.

Function
REQ-016 States SHALL be IDLE and RUN only.
REQ-017 In IDLE, outputs SHALL be: cmd_ready=1, busy=0, sel_mux=00, sr=0, sl=0.
REQ-018 A command SHALL be accepted when cmd_valid and cmd_ready are high on the same edge; all cmd_* fields are latched and the FSM moves to RUN on that edge.
REQ-019 In RUN, cmd_ready SHALL be 0, busy SHALL be 1, and sel_mux SHALL equal the latched op; the first step's outputs are valid in the cycle after acceptance.
REQ-020 For op 11, in SHALL equal the latched data, and the step count SHALL be forced to 1 regardless of cmd_cnt.
REQ-021 in SHALL hold the last latched data at all other times; after reset its value is 0.
REQ-022 For op 01, sr SHALL equal serial[idx] and sl SHALL be 0.
REQ-023 For op 10, sl SHALL equal serial[idx] and sr SHALL be 0.
REQ-024 For ops 00 and 11, sr and sl SHALL both be 0.
REQ-025 The step index idx SHALL be a 3-bit counter starting at 0 and incrementing on each step_en in RUN.
REQ-026 A remaining-steps counter (4 bits, range 1..8) SHALL decrement on each step_en in RUN.
REQ-027 The outputs present in the step_en cycle SHALL be the values captured downstream; they SHALL change only on the edge that ends a step_en cycle.
REQ-028 On step_en with remaining=1: the FSM SHALL return to IDLE, sel_mux=00, and done=1 for exactly the following cycle.
REQ-029 cmd_ready SHALL be high during that done cycle, so back-to-back accepts are possible.
REQ-030 step_en SHALL be ignored in IDLE and in the acceptance cycle.
REQ-031 cmd_valid SHALL be ignored while in RUN.
REQ-032 Any cmd_op value SHALL be legal; op 00 SHALL occupy cnt steps with sel_mux=00.

Reset
REQ-033 When clr=1 at an edge, the block SHALL enter IDLE with the IDLE outputs of REQ-017, plus in=0, done=0, idx=0 and remaining=0.
REQ-034 clr SHALL take priority over step_en and over a command accept in the same cycle.
REQ-035 clr during RUN SHALL abort the command with no done pulse.

Structure
REQ-036 The op encodings (HOLD, SHR, SHL, LOAD), the state encodings and the default widths SHALL live in a shared package/include, usr_pkg, which the shift-register stage also uses.
REQ-037 The block SHALL be a single module with no sub-module.
REQ-038 The bench SHALL instantiate usr_sequencer driving the existing 4-bit universal shift register, with step_en derived from the divided clock.

Verification
REQ-039 Load: cmd op=11, data=1010, cnt=5 -> exactly one step with sel_mux=11 and in=1010; done after the first step_en; shift register q=1010.
REQ-040 Shift right: q=0000, op=01, cnt=4, serial=8'b0000_1011 -> sr sequence 1,1,0,1; final q=1011; done after the 4th step_en.
REQ-041 Shift left with cnt=0: op=10, serial=8'hA5 -> 8 steps with sl = 1,0,1,0,0,1,0,1; done after the 8th step_en.
REQ-042 Back-to-back: cmd_valid held high with a second command queued -> second command accepted in the done cycle; no step_en lost or duplicated.
REQ-043 Reset mid-RUN: clr asserted after 2 of 6 steps -> next cycle IDLE, sel_mux=00, no done pulse.
REQ-044 Simultaneous clr and step_en -> clr wins.
